// File: rtl/keypad_scanner_if.sv
// Signal bundle between the 4x4 keypad matrix, the scanner and the downstream debouncer.
// The master side is the scanner; the slave side is the keypad/consumer view.
interface keypad_scanner_if;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] key_code;
    logic       key_pressed;
    logic       key_valid;

    modport master (
        input  rows,
        output cols,
        output key_code,
        output key_pressed,
        output key_valid
    );

    modport slave (
        output rows,
        input  cols,
        input  key_code,
        input  key_pressed,
        input  key_valid
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks one active-low column at a time, locks onto the first
// pressed key, reports its hex code and holds the column until that key is released.
module keypad_scanner #(
    parameter int SCAN_DIV = 48000
) (
    input logic              clk,
    input logic              reset,
    keypad_scanner_if.master kp
);

    localparam int            CW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    typedef enum logic {
        ST_SCAN,
        ST_HOLD
    } state_t;

    state_t        r_state;
    logic [1:0]    r_colIdx;
    logic [1:0]    r_rowIdx;
    logic [3:0]    r_cols;
    logic [CW-1:0] r_divCnt;
    logic [3:0]    r_rowsMeta;
    logic [3:0]    r_rowsSync;
    logic [3:0]    r_keyCode;
    logic          r_keyPressed;
    logic          r_keyValid;

    logic          w_tick;
    logic          w_anyLow;
    logic [1:0]    w_lowRow;
    logic [1:0]    w_nextCol;

    function automatic logic [3:0] colDrive(input logic [1:0] idx);
        colDrive = ~(4'b0001 << idx);
    endfunction

    function automatic logic [1:0] lowestLow(input logic [3:0] r);
        if (!r[0])      lowestLow = 2'd0;
        else if (!r[1]) lowestLow = 2'd1;
        else if (!r[2]) lowestLow = 2'd2;
        else            lowestLow = 2'd3;
    endfunction

    function automatic logic [3:0] keyMap(input logic [1:0] row, input logic [1:0] col);
        case ({row, col})
            4'b00_00: keyMap = 4'h1;
            4'b00_01: keyMap = 4'h2;
            4'b00_10: keyMap = 4'h3;
            4'b00_11: keyMap = 4'hA;
            4'b01_00: keyMap = 4'h4;
            4'b01_01: keyMap = 4'h5;
            4'b01_10: keyMap = 4'h6;
            4'b01_11: keyMap = 4'hB;
            4'b10_00: keyMap = 4'h7;
            4'b10_01: keyMap = 4'h8;
            4'b10_10: keyMap = 4'h9;
            4'b10_11: keyMap = 4'hC;
            4'b11_00: keyMap = 4'hE;
            4'b11_01: keyMap = 4'h0;
            4'b11_10: keyMap = 4'hF;
            default:  keyMap = 4'hD;
        endcase
    endfunction

    assign w_tick    = (r_divCnt == LAST);
    assign w_anyLow  = ~&r_rowsSync;
    assign w_lowRow  = lowestLow(r_rowsSync);
    assign w_nextCol = r_colIdx + 2'd1;

    // Rows idle high through the pull-ups, so the synchronizer resets to "no key".
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rowsMeta <= 4'hF;
            r_rowsSync <= 4'hF;
        end else begin
            r_rowsMeta <= kp.rows;
            r_rowsSync <= r_rowsMeta;
        end
    end

    // The dwell counter only wraps on a tick, and the column only moves on a tick, so every
    // new column starts with a full dwell that covers the synchronizer latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_SCAN;
            r_colIdx     <= 2'd0;
            r_rowIdx     <= 2'd0;
            r_cols       <= 4'b1110;
            r_divCnt     <= '0;
            r_keyCode    <= 4'h0;
            r_keyPressed <= 1'b0;
            r_keyValid   <= 1'b0;
        end else begin
            r_keyValid <= 1'b0;
            r_divCnt   <= w_tick ? '0 : r_divCnt + CW'(1);
            case (r_state)
                ST_SCAN: begin
                    if (w_tick) begin
                        if (w_anyLow) begin
                            r_rowIdx     <= w_lowRow;
                            r_keyCode    <= keyMap(w_lowRow, r_colIdx);
                            r_keyPressed <= 1'b1;
                            r_keyValid   <= 1'b1;
                            r_state      <= ST_HOLD;
                        end else begin
                            r_colIdx <= w_nextCol;
                            r_cols   <= colDrive(w_nextCol);
                        end
                    end
                end
                ST_HOLD: begin
                    // Only the locked row on the locked column can end the hold.
                    if (w_tick && r_rowsSync[r_rowIdx]) begin
                        r_keyPressed <= 1'b0;
                        r_colIdx     <= w_nextCol;
                        r_cols       <= colDrive(w_nextCol);
                        r_state      <= ST_SCAN;
                    end
                end
                default: begin
                    r_state <= ST_SCAN;
                end
            endcase
        end
    end

    assign kp.cols        = r_cols;
    assign kp.key_code    = r_keyCode;
    assign kp.key_pressed = r_keyPressed;
    assign kp.key_valid   = r_keyValid;

endmodule
